// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, bubble word
// and stall-vector bit positions.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_HOLD = 2'd2,
        IF_DROP = 2'd3
    } if_state_e;

    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0000;

    localparam int unsigned STALL_IF = 0;
    localparam int unsigned STALL_ID = 1;

endpackage

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory and presents a registered IR_o/pc_o pair to ID.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  stall_i,
    input  logic        branch_en_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] IR_o,
    output logic [31:0] pc_o
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pco_q, pco_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_w_q, skid_w_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        ack;
    logic        unused_stall;

    assign unused_stall = ^stall_i[5:2];
    assign ack          = req_q & imem_ack_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IF_IDLE;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            ir_q      <= NOP_INSTR;
            pco_q     <= RESET_PC;
            skid_v_q  <= 1'b0;
            skid_w_q  <= NOP_INSTR;
            skid_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            ir_q      <= ir_d;
            pco_q     <= pco_d;
            skid_v_q  <= skid_v_d;
            skid_w_q  <= skid_w_d;
            skid_pc_q <= skid_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = req_q;
        addr_d    = addr_q;
        ir_d      = ir_q;
        pco_d     = pco_q;
        skid_v_d  = skid_v_q;
        skid_w_d  = skid_w_q;
        skid_pc_d = skid_pc_q;

        if (branch_en_i) begin
            pc_d     = branch_target_i;
            skid_v_d = 1'b0;
            ir_d     = NOP_INSTR;
            // An unacked request must stay on the bus; park in DROP until it completes.
            if (req_q && !imem_ack_i) begin
                state_d = IF_DROP;
            end else begin
                state_d = IF_REQ;
                req_d   = 1'b0;
            end
        end else begin
            unique case (state_q)
                IF_IDLE: state_d = IF_REQ;
                IF_REQ: begin
                    if (ack) begin
                        pc_d = pc_q + 32'd4;
                        if (stall_i[STALL_ID]) begin
                            skid_v_d  = 1'b1;
                            skid_w_d  = imem_rdata_i;
                            skid_pc_d = pc_q;
                            req_d     = 1'b0;
                            state_d   = IF_HOLD;
                        end else begin
                            ir_d  = imem_rdata_i;
                            pco_d = pc_q;
                            req_d = !stall_i[STALL_IF];
                            if (!stall_i[STALL_IF]) addr_d = pc_q + 32'd4;
                        end
                    end else begin
                        if (!req_q && !stall_i[STALL_IF]) begin
                            req_d  = 1'b1;
                            addr_d = pc_q;
                        end
                        if (!stall_i[STALL_ID]) ir_d = NOP_INSTR;
                    end
                end
                IF_HOLD: begin
                    if (!stall_i[STALL_ID]) begin
                        ir_d     = skid_v_q ? skid_w_q : NOP_INSTR;
                        pco_d    = skid_pc_q;
                        skid_v_d = 1'b0;
                        state_d  = IF_REQ;
                    end
                end
                IF_DROP: begin
                    if (ack) begin
                        req_d   = 1'b0;
                        state_d = IF_REQ;
                    end
                end
                default: state_d = IF_IDLE;
            endcase
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign IR_o        = ir_q;
    assign pc_o        = pco_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed vector table, asynchronous reset sequence and a
// randomized run checked against a program-order fetch model.
module tb_ifetch;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stall;
    logic        br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] ir;
    logic [31:0] pco;
    logic        rdata_inv = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb rdata = rdata_inv ? ~addr : addr;

    ifetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall_i(stall),
        .branch_en_i(br),
        .branch_target_i(tgt),
        .imem_req_o(req),
        .imem_addr_o(addr),
        .imem_ack_i(ack),
        .imem_rdata_i(rdata),
        .IR_o(ir),
        .pc_o(pco)
    );

    typedef struct {
        logic [5:0]  stall;
        logic        br;
        logic [31:0] tgt;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_ir;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] s, input logic b, input logic [31:0] t, input logic a,
                       input logic er, input logic [31:0] ea, input logic [31:0] ei,
                       input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t; v.ack = a;
        v.exp_req = er; v.exp_addr = ea; v.exp_ir = ei; v.exp_pc = ep;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = '0; br = 1'b0; tgt = '0; ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_pc", pco, 32'h0);
        rst_n = 1'b1;
    endtask

    // Random-phase model state: program-order expectations only.
    logic [31:0] exp_next;
    logic        p_req, p_ack, p_br;
    logic [31:0] p_addr, p_tgt, p_ir, p_pc;
    logic [5:0]  p_stall;
    int          delivered;
    int          idle;

    initial begin
        // stall, br, tgt, ack -> req, addr, IR, pc
        add(6'h00, 0, 32'h0,   0, 0, 32'h00,  32'h00,  32'h00);
        add(6'h00, 0, 32'h0,   0, 1, 32'h00,  32'h00,  32'h00);
        add(6'h00, 0, 32'h0,   1, 1, 32'h04,  32'h00,  32'h00);
        add(6'h3C, 0, 32'h0,   1, 1, 32'h08,  32'h04,  32'h04);
        add(6'h00, 0, 32'h0,   0, 1, 32'h08,  32'h00,  32'h04);
        add(6'h00, 0, 32'h0,   0, 1, 32'h08,  32'h00,  32'h04);
        add(6'h00, 0, 32'h0,   0, 1, 32'h08,  32'h00,  32'h04);
        add(6'h00, 0, 32'h0,   1, 1, 32'h0C,  32'h08,  32'h08);
        add(6'h3C, 0, 32'h0,   1, 1, 32'h10,  32'h0C,  32'h0C);
        add(6'h02, 0, 32'h0,   1, 0, 32'h10,  32'h0C,  32'h0C);
        add(6'h02, 0, 32'h0,   1, 0, 32'h10,  32'h0C,  32'h0C);
        add(6'h00, 0, 32'h0,   0, 0, 32'h10,  32'h10,  32'h10);
        add(6'h00, 0, 32'h0,   0, 1, 32'h14,  32'h00,  32'h10);
        add(6'h00, 1, 32'h40,  0, 1, 32'h14,  32'h00,  32'h10);
        add(6'h00, 0, 32'h0,   0, 1, 32'h14,  32'h00,  32'h10);
        add(6'h00, 0, 32'h0,   1, 0, 32'h14,  32'h00,  32'h10);
        add(6'h00, 0, 32'h0,   0, 1, 32'h40,  32'h00,  32'h10);
        add(6'h00, 0, 32'h0,   1, 1, 32'h44,  32'h40,  32'h40);
        add(6'h02, 0, 32'h0,   1, 0, 32'h44,  32'h40,  32'h40);
        add(6'h02, 1, 32'h80,  0, 0, 32'h44,  32'h00,  32'h40);
        add(6'h01, 0, 32'h0,   0, 0, 32'h44,  32'h00,  32'h40);
        add(6'h00, 0, 32'h0,   0, 1, 32'h80,  32'h00,  32'h40);
        add(6'h01, 0, 32'h0,   1, 0, 32'h80,  32'h80,  32'h80);
        add(6'h00, 0, 32'h0,   0, 1, 32'h84,  32'h00,  32'h80);
        add(6'h01, 0, 32'h0,   0, 1, 32'h84,  32'h00,  32'h80);
        add(6'h00, 0, 32'h0,   1, 1, 32'h88,  32'h84,  32'h84);
        add(6'h00, 1, 32'h100, 1, 0, 32'h88,  32'h00,  32'h84);
        add(6'h00, 0, 32'h0,   0, 1, 32'h100, 32'h00,  32'h84);
        add(6'h00, 0, 32'h0,   1, 1, 32'h104, 32'h100, 32'h100);

        do_reset();
        foreach (vecs[i]) begin
            stall = vecs[i].stall; br = vecs[i].br; tgt = vecs[i].tgt; ack = vecs[i].ack;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'd0, req}, {31'd0, vecs[i].exp_req});
            chk($sformatf("v%0d_addr", i), addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_ir", i), ir, vecs[i].exp_ir);
            chk($sformatf("v%0d_pc", i), pco, vecs[i].exp_pc);
        end

        // Reset asserted while a request is on the bus takes effect without a clock edge.
        stall = '0; br = 1'b0; ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", {31'd0, req}, 32'd0);
        chk("async_addr", addr, 32'h0);
        chk("async_ir", ir, 32'h0);
        chk("async_pc", pco, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel1_req", {31'd0, req}, 32'd0);
        @(negedge clk);
        chk("rel2_req", {31'd0, req}, 32'd1);
        chk("rel2_addr", addr, 32'h0);

        // Randomized run: memory returns ~addr so no real word looks like a bubble.
        rdata_inv = 1'b1;
        do_reset();
        exp_next = 32'h0; delivered = 0; idle = 0;
        for (int c = 0; c < 4000; c++) begin
            stall[0]   = ($urandom_range(0, 4) == 0);
            stall[1]   = ($urandom_range(0, 3) == 0);
            stall[5:2] = 4'($urandom_range(0, 15));
            br         = ($urandom_range(0, 15) == 0);
            tgt        = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            ack        = ($urandom_range(0, 2) != 0);
            p_req = req; p_addr = addr; p_ack = ack; p_br = br; p_tgt = tgt;
            p_stall = stall; p_ir = ir; p_pc = pco;
            @(negedge clk);
            if (p_req && !p_ack) begin
                chk("hs_req_held", {31'd0, req}, 32'd1);
                chk("hs_addr_held", addr, p_addr);
            end else if (!p_req && p_stall[0]) begin
                chk("stall_if_noreq", {31'd0, req}, 32'd0);
            end
            idle++;
            if (p_br) begin
                chk("flush_nop", ir, 32'h0);
                exp_next = p_tgt;
            end else if (p_stall[1]) begin
                chk("stall_id_ir", ir, p_ir);
                chk("stall_id_pc", pco, p_pc);
            end else if (ir != 32'h0 && (ir != p_ir || pco != p_pc)) begin
                chk("order_pc", pco, exp_next);
                chk("order_word", ir, ~pco);
                exp_next = pco + 32'd4;
                delivered++;
                idle = 0;
            end
            if (idle > 300) begin
                tests++; fails++;
                $display("FAIL liveness: got %0d idle cycles required at most 300", idle);
                idle = 0;
            end
        end
        tests++;
        if (delivered < 200) begin
            fails++;
            $display("FAIL throughput: got %0d deliveries required at least 200", delivered);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
